// File: rtl/slip_uart_tx.sv
// SLIP (RFC 1055) framing UART transmitter: 9-bit entry FIFO, escape encoder and 8N1 serialiser.
// Optional leading END per frame is enabled by defining SLIP_UART_TX_LEADING_END_EN.
`timescale 1ns/1ps

module slip_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned FIFO_AW      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_wr_en,
    input  logic [7:0] i_wr_byte,
    input  logic       i_wr_last,
    output logic       o_full,
    output logic       o_overflow,
    output logic       o_uart_tx,
    output logic       o_busy,
    output logic       o_frame_done
);

    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam int unsigned PW    = FIFO_AW + 1;
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [7:0] SLIP_END     = 8'hC0;
    localparam logic [7:0] SLIP_ESC     = 8'hDB;
    localparam logic [7:0] SLIP_ESC_END = 8'hDC;
    localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

    typedef enum logic [2:0] {
        E_IDLE,
        E_LEAD_END,
        E_DATA,
        E_ESC2,
        E_TRAIL_END
    } enc_state_t;

    typedef enum logic [1:0] {
        U_IDLE,
        U_START,
        U_DATA,
        U_STOP
    } uart_state_t;

    logic [8:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic          r_overflow;
    logic          w_full;
    logic          w_empty;
    logic          w_wr;
    logic          w_pop;
    logic [8:0]    w_rd_entry;

    enc_state_t    r_enc_state;
    enc_state_t    w_enc_next;
    logic [7:0]    r_esc;
    logic          r_last;
    logic          r_end_sent;
    logic          r_busy;
    logic          r_frame_done;
    logic          w_load;
    logic [7:0]    w_load_byte;
    logic          w_done;

    uart_state_t      r_u_state;
    uart_state_t      w_u_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [2:0]       r_bit;
    logic [2:0]       w_bit_next;
    logic [7:0]       r_sh;
    logic [7:0]       w_sh_next;
    logic             r_tx;
    logic             w_tx_next;
    logic             w_u_ready;
    logic             w_u_stop_end;

    // ---------------- FIFO ----------------
    assign w_full     = (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]) &&
                        (r_wptr[FIFO_AW] != r_rptr[FIFO_AW]);
    assign w_empty    = (r_wptr == r_rptr);
    assign w_wr       = i_wr_en && !w_full;
    assign w_rd_entry = r_mem[r_rptr[FIFO_AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr[FIFO_AW-1:0]] <= {i_wr_last, i_wr_byte};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            // Full is judged before any same-cycle pop, so such a write is still dropped.
            r_overflow <= i_wr_en && w_full;
        end
    end

    // ---------------- SLIP encoder ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_enc_state  <= E_IDLE;
            r_esc        <= '0;
            r_last       <= 1'b0;
            r_end_sent   <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_enc_state  <= w_enc_next;
            r_frame_done <= w_done;
            if (w_pop) begin
                r_last <= w_rd_entry[8];
                r_esc  <= (w_rd_entry[7:0] == SLIP_END) ? SLIP_ESC_END : SLIP_ESC_ESC;
            end
            if (r_enc_state == E_TRAIL_END && w_load) begin
                r_end_sent <= 1'b1;
            end else if (w_done) begin
                r_end_sent <= 1'b0;
            end
            if (r_enc_state == E_IDLE && w_enc_next != E_IDLE) begin
                r_busy <= 1'b1;
            end else if (w_done) begin
                r_busy <= 1'b0;
            end
        end
    end

    always_comb begin
        w_enc_next  = r_enc_state;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_load_byte = '0;
        w_done      = 1'b0;
        case (r_enc_state)
            E_IDLE: begin
                if (!w_empty) begin
`ifdef SLIP_UART_TX_LEADING_END_EN
                    w_enc_next = E_LEAD_END;
`else
                    w_enc_next = E_DATA;
`endif
                end
            end
            E_LEAD_END: begin
                if (w_u_ready) begin
                    w_load      = 1'b1;
                    w_load_byte = SLIP_END;
                    w_enc_next  = E_DATA;
                end
            end
            E_DATA: begin
                if (w_u_ready && !w_empty) begin
                    w_pop  = 1'b1;
                    w_load = 1'b1;
                    if (w_rd_entry[7:0] == SLIP_END || w_rd_entry[7:0] == SLIP_ESC) begin
                        w_load_byte = SLIP_ESC;
                        w_enc_next  = E_ESC2;
                    end else begin
                        w_load_byte = w_rd_entry[7:0];
                        w_enc_next  = w_rd_entry[8] ? E_TRAIL_END : E_DATA;
                    end
                end
            end
            E_ESC2: begin
                if (w_u_ready) begin
                    w_load      = 1'b1;
                    w_load_byte = r_esc;
                    w_enc_next  = r_last ? E_TRAIL_END : E_DATA;
                end
            end
            E_TRAIL_END: begin
                // The END is loaded first; completion is the stop bit of that END, not of the byte before it.
                if (!r_end_sent) begin
                    if (w_u_ready) begin
                        w_load      = 1'b1;
                        w_load_byte = SLIP_END;
                    end
                end else if (w_u_stop_end) begin
                    w_done     = 1'b1;
                    w_enc_next = E_IDLE;
                end
            end
            default: w_enc_next = E_IDLE;
        endcase
    end

    // ---------------- UART serialiser ----------------
    assign w_u_stop_end = (r_u_state == U_STOP) && (r_cnt == CNT_LAST);
    assign w_u_ready    = (r_u_state == U_IDLE) || w_u_stop_end;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_u_state <= U_IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_sh      <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_u_state <= w_u_next;
            r_cnt     <= w_cnt_next;
            r_bit     <= w_bit_next;
            r_sh      <= w_sh_next;
            r_tx      <= w_tx_next;
        end
    end

    always_comb begin
        w_u_next   = r_u_state;
        w_cnt_next = r_cnt;
        w_bit_next = r_bit;
        w_sh_next  = r_sh;
        case (r_u_state)
            U_IDLE: begin
                w_cnt_next = '0;
                if (w_load) begin
                    w_u_next  = U_START;
                    w_sh_next = w_load_byte;
                end
            end
            U_START: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_next = '0;
                    w_bit_next = '0;
                    w_u_next   = U_DATA;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            U_DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_next = '0;
                    if (r_bit == 3'd7) begin
                        w_u_next = U_STOP;
                    end else begin
                        w_bit_next = r_bit + 3'd1;
                        w_sh_next  = {1'b0, r_sh[7:1]};
                    end
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            U_STOP: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_next = '0;
                    if (w_load) begin
                        w_u_next  = U_START;
                        w_sh_next = w_load_byte;
                    end else begin
                        w_u_next = U_IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            default: w_u_next = U_IDLE;
        endcase
    end

    always_comb begin
        w_tx_next = 1'b1;
        case (w_u_next)
            U_START: w_tx_next = 1'b0;
            U_DATA:  w_tx_next = w_sh_next[0];
            default: w_tx_next = 1'b1;
        endcase
    end

    assign o_full       = w_full;
    assign o_overflow   = r_overflow;
    assign o_uart_tx    = r_tx;
    assign o_busy       = r_busy;
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_slip_uart_tx.sv
// Self-checking bench for slip_uart_tx: directed scenarios plus random frames, with a
// wire-level UART decoder compared against a byte-stream SLIP model.
`timescale 1ns/1ps

module tb_slip_uart_tx;

    localparam int unsigned CPB      = 4;
    localparam int unsigned AW       = 2;
    localparam int unsigned BYTE_CYC = 10 * CPB;
`ifdef SLIP_UART_TX_LEADING_END_EN
    localparam int unsigned LEAD_N = 1;
`else
    localparam int unsigned LEAD_N = 0;
`endif

    logic       clk;
    logic       reset;
    logic       i_wr_en;
    logic [7:0] i_wr_byte;
    logic       i_wr_last;
    logic       o_full;
    logic       o_overflow;
    logic       o_uart_tx;
    logic       o_busy;
    logic       o_frame_done;

    slip_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_AW     (AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_wr_en     (i_wr_en),
        .i_wr_byte   (i_wr_byte),
        .i_wr_last   (i_wr_last),
        .o_full      (o_full),
        .o_overflow  (o_overflow),
        .o_uart_tx   (o_uart_tx),
        .o_busy      (o_busy),
        .o_frame_done(o_frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Observations from the line and pulse outputs
    logic [7:0]  wire_q[$];
    int unsigned start_q[$];
    bit          sbusy_q[$];
    int unsigned done_q[$];
    bit          done_busy_q[$];
    int unsigned done_cnt = 0;
    int unsigned ovf_cnt  = 0;
    int unsigned ferr     = 0;

    // Reference stream and the frame under construction
    logic [7:0]  exp_q[$];
    logic [7:0]  frm[$];
    int unsigned last_wr_cyc;

    always @(negedge clk) begin
        if (o_frame_done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_q.push_back(cyc);
            done_busy_q.push_back(o_busy);
        end
        if (o_overflow === 1'b1) ovf_cnt <= ovf_cnt + 1;
    end

    initial begin : uart_decoder
        logic [7:0]  b;
        int unsigned s;
        bit          bz;
        forever begin
            @(negedge clk);
            if (o_uart_tx === 1'b0) begin
                s  = cyc;
                bz = o_busy;
                repeat (CPB / 2) @(negedge clk);
                if (o_uart_tx !== 1'b0) ferr++;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = o_uart_tx;
                end
                repeat (CPB) @(negedge clk);
                if (o_uart_tx !== 1'b1) ferr++;
                wire_q.push_back(b);
                start_q.push_back(s);
                sbusy_q.push_back(bz);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] b, input logic last);
        int unsigned n = 0;
        while (o_full === 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) chk("wr_full_timeout", o_full, 0);
        i_wr_en     = 1'b1;
        i_wr_byte   = b;
        i_wr_last   = last;
        last_wr_cyc = cyc;
        tick();
        i_wr_en     = 1'b0;
        i_wr_last   = 1'b0;
    endtask

    task automatic write_frm();
        for (int i = 0; i < frm.size(); i++) wr(frm[i], (i == frm.size() - 1));
    endtask

    // RFC 1055 byte stream for one frame
    task automatic model_frm();
        if (LEAD_N != 0) exp_q.push_back(8'hC0);
        foreach (frm[i]) begin
            if (frm[i] == 8'hC0) begin
                exp_q.push_back(8'hDB);
                exp_q.push_back(8'hDC);
            end else if (frm[i] == 8'hDB) begin
                exp_q.push_back(8'hDB);
                exp_q.push_back(8'hDD);
            end else begin
                exp_q.push_back(frm[i]);
            end
        end
        exp_q.push_back(8'hC0);
    endtask

    task automatic wait_done(input int unsigned target);
        int unsigned n = 0;
        while (done_cnt < target && n < 6000) begin
            tick();
            n++;
        end
        chk("done_timeout", (done_cnt >= target), 1);
        repeat (4) tick();
    endtask

    function automatic int unsigned sq(input int unsigned i);
        return (i < start_q.size()) ? start_q[i] : 0;
    endfunction

    task automatic cmp_wire(input string tag);
        int unsigned n;
        chk({tag, "_nbytes"}, wire_q.size(), exp_q.size());
        n = (wire_q.size() < exp_q.size()) ? wire_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_byte%0d", tag, i), wire_q[i], exp_q[i]);
        for (int i = 0; i < sbusy_q.size(); i++)
            chk($sformatf("%s_busy_at_start%0d", tag, i), sbusy_q[i], 1);
        for (int i = 0; i < done_busy_q.size(); i++)
            chk($sformatf("%s_busy_at_done%0d", tag, i), done_busy_q[i], 0);
        wire_q.delete();
        exp_q.delete();
        start_q.delete();
        sbusy_q.delete();
        done_q.delete();
        done_busy_q.delete();
    endtask

    initial begin : stimulus
        int unsigned w0;
        int unsigned n;
        int unsigned dbase;
        int unsigned obase;
        logic [7:0]  rb[4];
        logic [7:0]  x;
        logic [7:0]  y;

        reset     = 1'b0;
        i_wr_en   = 1'b0;
        i_wr_byte = '0;
        i_wr_last = 1'b0;
        repeat (3) tick();
        chk("rst_tx", o_uart_tx, 1);
        chk("rst_full", o_full, 0);
        chk("rst_overflow", o_overflow, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_frame_done", o_frame_done, 0);
        reset = 1'b1;
        repeat (2) tick();

        // Single byte frame: latency, back-to-back bytes, done timing
        frm = '{8'h41};
        model_frm();
        dbase = done_cnt;
        wr(8'h41, 1'b1);
        w0 = last_wr_cyc;
        wait_done(dbase + 1);
        n = exp_q.size();
        chk("t1_done_count", done_cnt - dbase, 1);
        chk("t1_first_start", sq(0), w0 + 3);
        chk("t1_data_start", sq(LEAD_N), w0 + 3 + LEAD_N * BYTE_CYC);
        chk("t1_span", sq(n - 1) - sq(0), (n - 1) * BYTE_CYC);
        chk("t1_done_cycle", (done_q.size() > 0) ? done_q[0] : 0, w0 + 3 + n * BYTE_CYC);
        cmp_wire("t1");

        // Escapes with zero gap
        frm = '{8'hC0, 8'hDB, 8'h00};
        model_frm();
        dbase = done_cnt;
        write_frm();
        wait_done(dbase + 1);
        n = exp_q.size();
        chk("t2_span", sq(n - 1) - sq(0), (n - 1) * BYTE_CYC);
        cmp_wire("t2");

        // Overflow: fill the 4-deep FIFO while a byte is on the wire
        obase = ovf_cnt;
        dbase = done_cnt;
        for (int i = 0; i < 4; i++) rb[i] = 8'($urandom_range(0, 255));
        wr(8'h55, 1'b0);
        repeat (10 + LEAD_N * BYTE_CYC) tick();
        for (int i = 0; i < 5; i++) begin
            i_wr_en   = 1'b1;
            i_wr_byte = (i < 4) ? rb[i] : 8'h99;
            i_wr_last = (i == 3);
            tick();
            if (i == 2) chk("t3_full_after_3", o_full, 0);
            if (i == 3) chk("t3_full_after_4", o_full, 1);
        end
        i_wr_en   = 1'b0;
        i_wr_last = 1'b0;
        repeat (2) tick();
        chk("t3_overflow_pulses", ovf_cnt - obase, 1);
        frm = '{8'h55, rb[0], rb[1], rb[2], rb[3]};
        model_frm();
        wait_done(dbase + 1);
        chk("t3_full_drained", o_full, 0);
        cmp_wire("t3");

        // Underrun: line idle high mid-frame
        dbase = done_cnt;
        frm = '{8'h11, 8'h22};
        model_frm();
        wr(8'h11, 1'b0);
        repeat (94) tick();
        chk("t4_idle_line", o_uart_tx, 1);
        chk("t4_busy_held", o_busy, 1);
        chk("t4_bytes_so_far", wire_q.size(), 1 + LEAD_N);
        repeat (5) tick();
        wr(8'h22, 1'b1);
        wait_done(dbase + 1);
        cmp_wire("t4");

        // Reset in a data bit of the second wire byte
        dbase = done_cnt;
        wr(8'h00, 1'b0);
        w0 = last_wr_cyc;
        wr(8'h00, 1'b0);
        wr(8'h7E, 1'b1);
        while (cyc < w0 + 3 + BYTE_CYC + CPB + 3 * CPB + CPB / 2) tick();
        chk("t5_pre_reset_line", o_uart_tx, 0);
        reset = 1'b0;
        #1;
        chk("t5_reset_line", o_uart_tx, 1);
        chk("t5_reset_busy", o_busy, 0);
        chk("t5_reset_full", o_full, 0);
        repeat (3) tick();
        reset = 1'b1;
        repeat (60) tick();
        wire_q.delete();
        start_q.delete();
        sbusy_q.delete();
        repeat (60) tick();
        chk("t5_no_tx_after_reset", wire_q.size(), 0);
        chk("t5_no_done", done_cnt - dbase, 0);
        chk("t5_idle_after_reset", o_busy, 0);
        frm = '{8'($urandom_range(0, 255)), 8'hDB};
        model_frm();
        write_frm();
        wait_done(dbase + 1);
        cmp_wire("t5");

        // Two single-byte frames queued together
        dbase = done_cnt;
        x = 8'($urandom_range(0, 255));
        y = 8'($urandom_range(0, 255));
        frm = '{x};
        model_frm();
        write_frm();
        frm = '{y};
        model_frm();
        write_frm();
        wait_done(dbase + 2);
        repeat (50) tick();
        chk("t6_done_count", done_cnt - dbase, 2);
        cmp_wire("t6");

        // Random frames biased toward END/ESC bytes
        dbase = done_cnt;
        obase = ovf_cnt;
        for (int f = 0; f < 4; f++) begin
            frm.delete();
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 3))
                    0:       frm.push_back(8'hC0);
                    1:       frm.push_back(8'hDB);
                    default: frm.push_back(8'($urandom_range(0, 255)));
                endcase
            end
            model_frm();
            write_frm();
        end
        wait_done(dbase + 4);
        chk("t7_done_count", done_cnt - dbase, 4);
        chk("t7_no_overflow", ovf_cnt - obase, 0);
        cmp_wire("t7");

        chk("framing_errors", ferr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
